axi_sram_ctrl: RTL and testbench
================================

# axi_sram_ctrl

AXI slave endpoint that terminates an `axi_channel` and drives a single-port synchronous SRAM with 1-cycle read latency. It sits directly downstream of an `axi_buf` stage's slave-side port, consuming its AW/W/AR requests and producing B/R responses. It supports FIXED, INCR and WRAP bursts and narrow transfers, serving one transaction at a time with read/write round-robin arbitration.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, default 10: SRAM word-address width; SRAM holds 2^MEM_ADDR_WIDTH words of `master.DATA_WIDTH` bits.

Ports:
- `clk`  in  1  clock; same net as `master.clk`. One clock; reset is asynchronous and active-low.
- `rstn`  in  1  asynchronous active-low reset; same net as `master.rstn`.
- `master`  `axi_channel.slave`  -  AXI port. ID, data and user widths are taken from the interface.
- `mem_en`  out  1  SRAM access strobe.
- `mem_we`  out  1  write when `mem_en`=1.
- `mem_addr`  out  MEM_ADDR_WIDTH  word address.
- `mem_wstrb`  out  DATA_WIDTH/8  byte enables.
- `mem_wdata`  out  DATA_WIDTH  write data.
- `mem_rdata`  in  DATA_WIDTH  read data, valid the cycle after a read strobe.

## Operation
- States are IDLE, WR, WR_RESP, RD_ADDR and RD_DATA.
- **IDLE**
  - `aw_ready` = `aw_valid` & grant_w. `ar_ready` = `ar_valid` & ~grant_w.
  - grant_w = `aw_valid` & (~`ar_valid` | prefer_write).
  - On any grant, prefer_write is set to (granted was read). Reset value is 0, so read wins the first tie.
  - The handshake latches id, addr, len, size and burst into a shared context. beat_cnt is set to 0.
  - AW handshake goes to WR. AR handshake goes to RD_ADDR.
- **WR**
  - `w_ready`=1.
  - Each W handshake drives `mem_en`=`mem_we`=1, `mem_wstrb`=`w_strb`, `mem_wdata`=`w_data` and `mem_addr`=current word address. It then advances the address and increments beat_cnt.
  - The handshake with beat_cnt==len goes to WR_RESP. `w_last` is ignored; len alone terminates the burst.
- **WR_RESP**
  - `b_valid`=1, `b_id`=latched id, `b_resp`=OKAY, `b_user`=0.
  - On `b_ready`, go to IDLE.
- **RD_ADDR**
  - `mem_en`=1, `mem_we`=0, `mem_addr`=current word address.
  - Always goes to RD_DATA next cycle.
- **RD_DATA**
  - `r_valid`=1, `r_id`=latched id, `r_resp`=OKAY, `r_user`=0, `r_last`=(beat_cnt==len).
  - `r_data` = `mem_rdata` on the first RD_DATA cycle, then a capture register loaded on that cycle.
  - On `r_ready`, advance the address and increment beat_cnt. Go to IDLE if last, else RD_ADDR.
- **Address arithmetic**
  - Byte address has `master.ADDR_WIDTH` bits. Step = 1<<size.
  - FIXED: unchanged. INCR: addr+step, wrapping modulo 2^ADDR_WIDTH.
  - WRAP: container = (len+1)<<size. Upper bits are kept; the low offset is (addr+step) mod container.
  - Reserved burst 2'b11 is treated as INCR.
  - Word address = byte addr[ADDR_LSB +: MEM_ADDR_WIDTH], with ADDR_LSB = log2(DATA_WIDTH/8). Upper bits alias, no error.
- **Narrow and lock handling**
  - Narrow writes pass `w_strb` through unchanged. Narrow reads return the full word.
  - `aw_lock`/`ar_lock` are ignored and answered OKAY, never EXOKAY.

## Timing
- **Reset values:** state IDLE; prefer_write=0; all `*_valid` and `*_ready` outputs 0; `mem_en`=`mem_we`=0; other outputs 0.
- **Reset mid-burst:** the transaction is dropped and no B/R is issued.
- **Ready and valid rules:** `aw_ready`/`ar_ready` may depend combinationally on the valids. All valids out are from state only, and each is held until its handshake.
- **Read timing:** AR handshake at cycle 0 gives `mem_en` at cycle 1 and `r_valid` at cycle 2. Throughput is 1 beat per 2 cycles with zero backpressure.
- **Write timing:** AW handshake at cycle 0 gives `w_ready` from cycle 1, 1 beat per cycle. `b_valid` is asserted the cycle after the last W handshake.
- **Back-to-back:** a new AW/AR can be accepted the cycle after the B or last-R handshake.
- **Simultaneous AW/AR valid** is resolved by prefer_write only. The loser keeps its valid asserted.

## Structure
- Shared `axi_pkg` holds the burst encodings (FIXED=2'b00, INCR=2'b01, WRAP=2'b10) and the resp encodings (OKAY=2'b00).
- Block-local: the state enum.
- Sub-module `axi_burst_addr` is the combinational next-address calculator (addr, size, len, burst → next addr). It is reusable by later burst-splitting blocks.

## Test plan
- **INCR write:** AW addr=0x10, len=3, size=log2(bytes), then 4 W beats D0..D3 all-strobe. Expect SRAM words 4..7 (32-bit data) written in 4 consecutive cycles, then B with OKAY and matching id.
- **WRAP read:** AR addr=0x18, len=3, size=4B. Expect `mem_addr` sequence 6,7,4,5, and `r_last` only on the 4th beat.
- **FIXED and narrow:** FIXED write len=1 with strb 0x1 then 0x2 to addr 0x8. Expect both accesses to word 2 with those strobes. A subsequent read returns the merged word.
- **Arbitration:** AW and AR valid together from reset. Expect read served first, then write. A repeated tie is served write first.
- **Backpressure:** `r_ready`/`b_ready` low for 5 cycles. Expect `r_valid`/`b_valid` and all fields held stable, `mem_en` idle, and the capture register supplying `r_data`.
- **Reset mid-burst:** `rstn` low during beat 2 of a len=7 read. Expect all outputs at reset values immediately. After release, a fresh AR completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings used by slave endpoints and burst helpers.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_channel.sv
// AXI channel bundle; widths are carried as interface parameters.
interface axi_channel #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
) (
    input logic clk,
    input logic rstn
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [USER_WIDTH-1:0]   aw_user;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;

    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;

    logic                    ar_valid;
    logic                    ar_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [USER_WIDTH-1:0]   ar_user;

    logic                    r_valid;
    logic                    r_ready;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;

    modport master (
        input  clk, rstn,
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last, w_user,
        input  w_ready,
        input  b_valid, b_id, b_resp, b_user,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_user,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );

    modport slave (
        input  clk, rstn,
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_user,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last, w_user,
        output w_ready,
        output b_valid, b_id, b_resp, b_user,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_user,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user,
        input  r_ready
    );

endinterface

// File: rtl/axi_burst_addr.sv
// Combinational next-beat byte address for FIXED, INCR and WRAP bursts.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    assign step      = ADDR_WIDTH'(1) << size;
    assign incr_addr = addr + step;
    // Wrap containers are powers of two, so the modulo reduces to a mask.
    assign wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);

    always_comb begin
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_sram_ctrl.sv
// AXI slave terminating one transaction at a time onto a single-port SRAM
// with 1-cycle read latency; reads and writes share one burst context.
module axi_sram_ctrl
    import axi_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                              clk,
    input  logic                              rstn,
    axi_channel.slave                         master,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
    output logic [master.DATA_WIDTH/8-1:0]    mem_wstrb,
    output logic [master.DATA_WIDTH-1:0]      mem_wdata,
    input  logic [master.DATA_WIDTH-1:0]      mem_rdata
);
    localparam int DW       = master.DATA_WIDTH;
    localparam int AW       = master.ADDR_WIDTH;
    localparam int IW       = master.ID_WIDTH;
    localparam int ADDR_LSB = $clog2(DW / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t          state_reg, state_next;
    logic            prefer_write_reg, prefer_write_next;
    logic [IW-1:0]   ctx_id_reg;
    logic [AW-1:0]   ctx_addr_reg;
    logic [7:0]      ctx_len_reg;
    logic [2:0]      ctx_size_reg;
    logic [1:0]      ctx_burst_reg;
    logic [7:0]      beat_cnt_reg;
    logic [DW-1:0]   rdata_cap_reg;
    logic            rd_first_reg;

    logic            load_w;
    logic            load_r;
    logic            advance;
    logic            grant_w;
    logic            last_beat;
    logic [AW-1:0]   next_addr;
    logic [MEM_ADDR_WIDTH-1:0] word_addr;

    axi_burst_addr #(
        .ADDR_WIDTH (AW)
    ) u_burst_addr (
        .addr      (ctx_addr_reg),
        .size      (ctx_size_reg),
        .len       (ctx_len_reg),
        .burst     (ctx_burst_reg),
        .next_addr (next_addr)
    );

    assign word_addr = ctx_addr_reg[ADDR_LSB +: MEM_ADDR_WIDTH];
    assign last_beat = (beat_cnt_reg == ctx_len_reg);
    assign grant_w   = master.aw_valid & (~master.ar_valid | prefer_write_reg);

    assign master.b_resp = RESP_OKAY;
    assign master.b_user = '0;
    assign master.r_resp = RESP_OKAY;
    assign master.r_user = '0;

    always_comb begin
        state_next        = state_reg;
        prefer_write_next = prefer_write_reg;
        load_w            = 1'b0;
        load_r            = 1'b0;
        advance           = 1'b0;
        master.aw_ready   = 1'b0;
        master.ar_ready   = 1'b0;
        master.w_ready    = 1'b0;
        master.b_valid    = 1'b0;
        master.b_id       = '0;
        master.r_valid    = 1'b0;
        master.r_id       = '0;
        master.r_last     = 1'b0;
        master.r_data     = '0;
        mem_en            = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = '0;
        mem_wstrb         = '0;
        mem_wdata         = '0;

        case (state_reg)
            S_IDLE: begin
                // No handshakes while reset is held, even if a master drives valid.
                if (rstn) begin
                    if (grant_w) begin
                        master.aw_ready   = 1'b1;
                        load_w            = 1'b1;
                        prefer_write_next = 1'b0;
                        state_next        = S_WR;
                    end else if (master.ar_valid) begin
                        master.ar_ready   = 1'b1;
                        load_r            = 1'b1;
                        prefer_write_next = 1'b1;
                        state_next        = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                master.w_ready = 1'b1;
                if (master.w_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = word_addr;
                    mem_wstrb = master.w_strb;
                    mem_wdata = master.w_data;
                    advance   = 1'b1;
                    if (last_beat) begin
                        state_next = S_WR_RESP;
                    end
                end
            end
            S_WR_RESP: begin
                master.b_valid = 1'b1;
                master.b_id    = ctx_id_reg;
                if (master.b_ready) begin
                    state_next = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                mem_en     = 1'b1;
                mem_addr   = word_addr;
                state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                master.r_valid = 1'b1;
                master.r_id    = ctx_id_reg;
                master.r_last  = last_beat;
                // SRAM output is only valid the cycle after the strobe.
                master.r_data  = rd_first_reg ? mem_rdata : rdata_cap_reg;
                if (master.r_ready) begin
                    advance    = 1'b1;
                    state_next = last_beat ? S_IDLE : S_RD_ADDR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= S_IDLE;
            prefer_write_reg <= 1'b0;
            ctx_id_reg       <= '0;
            ctx_addr_reg     <= '0;
            ctx_len_reg      <= '0;
            ctx_size_reg     <= '0;
            ctx_burst_reg    <= '0;
            beat_cnt_reg     <= '0;
            rdata_cap_reg    <= '0;
            rd_first_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            prefer_write_reg <= prefer_write_next;
            rd_first_reg     <= (state_reg == S_RD_ADDR);
            if (rd_first_reg) begin
                rdata_cap_reg <= mem_rdata;
            end
            if (load_w) begin
                ctx_id_reg    <= master.aw_id;
                ctx_addr_reg  <= master.aw_addr;
                ctx_len_reg   <= master.aw_len;
                ctx_size_reg  <= master.aw_size;
                ctx_burst_reg <= master.aw_burst;
                beat_cnt_reg  <= '0;
            end else if (load_r) begin
                ctx_id_reg    <= master.ar_id;
                ctx_addr_reg  <= master.ar_addr;
                ctx_len_reg   <= master.ar_len;
                ctx_size_reg  <= master.ar_size;
                ctx_burst_reg <= master.ar_burst;
                beat_cnt_reg  <= '0;
            end else if (advance) begin
                ctx_addr_reg  <= next_addr;
                beat_cnt_reg  <= beat_cnt_reg + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_ctrl.sv
// Directed and randomized bench for axi_sram_ctrl with a word-level reference memory.
module tb_axi_sram_ctrl;
    import axi_pkg::*;

    localparam int MAW = 10;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(1))
        axi (.clk(clk), .rstn(rstn));

    logic           mem_en;
    logic           mem_we;
    logic [MAW-1:0] mem_addr;
    logic [3:0]     mem_wstrb;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata;

    axi_sram_ctrl #(.MEM_ADDR_WIDTH(MAW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .master    (axi),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // SRAM model: read data is garbage except the cycle after a read strobe.
    logic [31:0] sram [1024];
    logic        init_pending = 1'b1;
    always @(posedge clk) begin
        if (init_pending) begin
            for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
            init_pending <= 1'b0;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
        else                   mem_rdata <= $urandom;
    end

    logic [31:0] exp_mem [1024];
    logic [31:0] beat_data [256];
    logic [3:0]  beat_strb [256];
    int errors = 0;
    int checks = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte address of beat i, computed in closed form from the burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size,
                                              input int len, input logic [1:0] burst, input int i);
        longint step, cont, s, base;
        step = longint'(1) << size;
        s    = longint'(start);
        if (burst == BURST_FIXED) return start;
        if (burst == BURST_WRAP) begin
            cont = longint'(len + 1) * step;
            base = s - (s % cont);
            return 32'(base + ((s % cont) + longint'(i) * step) % cont);
        end
        return 32'(s + longint'(i) * step);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, {axi.aw_ready, axi.ar_ready, axi.w_ready}, 0);
        chk({tag, "_valid"}, {axi.b_valid, axi.r_valid}, 0);
        chk({tag, "_mem"}, {mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata}, 0);
        chk({tag, "_resp"}, {axi.r_data, axi.r_last, axi.r_id, axi.b_id}, 0);
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst);
        axi.aw_id = id; axi.aw_addr = addr; axi.aw_len = 8'(len); axi.aw_size = 3'(size);
        axi.aw_burst = burst; axi.aw_lock = 1'($urandom); axi.aw_valid = 1'b1;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst);
        axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = 8'(len); axi.ar_size = 3'(size);
        axi.ar_burst = burst; axi.ar_lock = 1'($urandom); axi.ar_valid = 1'b1;
    endtask

    task automatic wait_aw_hs(input string tag);
        int t = 0;
        @(negedge clk);
        while (axi.aw_ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        chk({tag, "_aw_timeout"}, (t < 40), 1);
        @(posedge clk); #1;
        axi.aw_valid = 1'b0;
    endtask

    task automatic wait_ar_hs(input string tag);
        int t = 0;
        @(negedge clk);
        while (axi.ar_ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        chk({tag, "_ar_timeout"}, (t < 40), 1);
        @(posedge clk); #1;
        axi.ar_valid = 1'b0;
    endtask

    task automatic write_beats(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input int size, input logic [1:0] burst, input int bp, input string tag);
        int w;
        for (int i = 0; i <= len; i++) begin
            axi.w_valid = 1'b1; axi.w_data = beat_data[i]; axi.w_strb = beat_strb[i];
            axi.w_last = (i == len);
            @(negedge clk);
            w = word_of(beat_addr(addr, size, len, burst, i));
            chk({tag, "_w_ready"}, axi.w_ready, 1);
            chk({tag, "_wr_beat"}, {mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata},
                {1'b1, 1'b1, 10'(w), beat_strb[i], beat_data[i]});
            for (int b = 0; b < 4; b++)
                if (beat_strb[i][b]) exp_mem[w][8*b +: 8] = beat_data[i][8*b +: 8];
            @(posedge clk); #1;
        end
        axi.w_valid = 1'b0; axi.w_last = 1'b0;
        axi.b_ready = (bp == 0);
        @(negedge clk);
        chk({tag, "_b"}, {axi.b_valid, axi.b_id, axi.b_resp}, {1'b1, id, RESP_OKAY});
        for (int k = 1; k <= bp; k++) begin
            @(posedge clk); #1;
            axi.b_ready = (k == bp);
            @(negedge clk);
            chk({tag, "_b_hold"}, {axi.b_valid, axi.b_id, axi.b_resp, axi.b_user, mem_en},
                {1'b1, id, RESP_OKAY, 1'b0, 1'b0});
        end
        @(posedge clk); #1;
        axi.b_ready = 1'b0;
        chk({tag, "_b_done"}, axi.b_valid, 0);
    endtask

    task automatic read_beats(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input int size, input logic [1:0] burst, input int bp,
                              input int bp_beat, input int abort_beat, input string tag);
        int w;
        logic lst;
        for (int i = 0; i <= len; i++) begin
            w   = word_of(beat_addr(addr, size, len, burst, i));
            lst = (i == len);
            axi.r_ready = !(bp > 0 && i == bp_beat);
            @(negedge clk);
            chk({tag, "_rd_strobe"}, {mem_en, mem_we, mem_addr, axi.r_valid},
                {1'b1, 1'b0, 10'(w), 1'b0});
            if (i == abort_beat) begin
                rstn = 1'b0;
                #1;
                check_idle_outputs({tag, "_reset"});
                axi.r_ready = 1'b0;
                return;
            end
            @(negedge clk);
            chk({tag, "_r_beat"}, {axi.r_valid, axi.r_id, axi.r_resp, axi.r_last, axi.r_data},
                {1'b1, id, RESP_OKAY, lst, exp_mem[w]});
            if (bp > 0 && i == bp_beat) begin
                for (int k = 1; k <= bp; k++) begin
                    @(posedge clk); #1;
                    axi.r_ready = (k == bp);
                    @(negedge clk);
                    chk({tag, "_r_hold"}, {axi.r_valid, axi.r_id, axi.r_last, axi.r_data, mem_en},
                        {1'b1, id, lst, exp_mem[w], 1'b0});
                end
            end
            @(posedge clk); #1;
        end
        axi.r_ready = 1'b0;
        chk({tag, "_r_done"}, axi.r_valid, 0);
    endtask

    task automatic write_txn(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input int size, input logic [1:0] burst, input int bp, input string tag);
        set_aw(id, addr, len, size, burst);
        wait_aw_hs(tag);
        write_beats(id, addr, len, size, burst, bp, tag);
    endtask

    task automatic read_txn(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input logic [1:0] burst, input int bp,
                            input int bp_beat, input int abort_beat, input string tag);
        set_ar(id, addr, len, size, burst);
        wait_ar_hs(tag);
        read_beats(id, addr, len, size, burst, bp, bp_beat, abort_beat, tag);
    endtask

    initial begin
        axi.aw_valid = 0; axi.aw_id = 0; axi.aw_addr = 0; axi.aw_len = 0; axi.aw_size = 0;
        axi.aw_burst = 0; axi.aw_lock = 0; axi.aw_user = 0;
        axi.w_valid = 0; axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0; axi.w_user = 0;
        axi.b_ready = 0;
        axi.ar_valid = 0; axi.ar_id = 0; axi.ar_addr = 0; axi.ar_len = 0; axi.ar_size = 0;
        axi.ar_burst = 0; axi.ar_lock = 0; axi.ar_user = 0;
        axi.r_ready = 0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Tie from reset: read first; a second tie with the write still waiting goes to write.
        beat_data[0] = 32'hA5A5_0001; beat_strb[0] = 4'hF;
        set_aw(4'd1, 32'h100, 0, 2, BURST_INCR);
        set_ar(4'd2, 32'h200, 0, 2, BURST_INCR);
        @(negedge clk);
        chk("arb_tie1", {axi.aw_ready, axi.ar_ready}, 2'b01);
        @(posedge clk); #1;
        set_ar(4'd3, 32'h100, 0, 2, BURST_INCR);
        read_beats(4'd2, 32'h200, 0, 2, BURST_INCR, 0, 0, -1, "arb_rd1");
        @(negedge clk);
        chk("arb_tie2", {axi.aw_ready, axi.ar_ready}, 2'b10);
        @(posedge clk); #1;
        axi.aw_valid = 1'b0;
        write_beats(4'd1, 32'h100, 0, 2, BURST_INCR, 0, "arb_wr");
        wait_ar_hs("arb_rd2");
        read_beats(4'd3, 32'h100, 0, 2, BURST_INCR, 0, 0, -1, "arb_rd2");

        for (int i = 0; i < 4; i++) begin
            beat_data[i] = 32'hD000_0000 + 32'(i); beat_strb[i] = 4'hF;
        end
        write_txn(4'd5, 32'h10, 3, 2, BURST_INCR, 0, "incr_wr");
        read_txn(4'd6, 32'h18, 3, 2, BURST_WRAP, 0, 0, -1, "wrap_rd");

        beat_data[0] = 32'h1122_3344; beat_strb[0] = 4'h1;
        beat_data[1] = 32'h5566_7788; beat_strb[1] = 4'h2;
        write_txn(4'd7, 32'h8, 1, 0, BURST_FIXED, 0, "fixed_wr");
        read_txn(4'd8, 32'h8, 0, 2, BURST_FIXED, 0, 0, -1, "fixed_rd");

        beat_data[0] = 32'hCAFE_0000; beat_strb[0] = 4'hF;
        beat_data[1] = 32'hCAFE_0001; beat_strb[1] = 4'hF;
        write_txn(4'd9, 32'h40, 1, 2, BURST_INCR, 5, "bp_wr");
        read_txn(4'd10, 32'h40, 1, 2, BURST_INCR, 5, 0, -1, "bp_rd");

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  bu;
            int          sz, ln, bp;
            logic [31:0] ad;
            bu = 2'($urandom_range(0, 3));
            sz = $urandom_range(0, 2);
            ln = (bu == BURST_WRAP) ? ((2 << $urandom_range(0, 3)) - 1) : $urandom_range(0, 7);
            ad = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 4095);
            ad = ad & ~((32'd1 << sz) - 32'd1);
            bp = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= ln; i++) begin
                    beat_data[i] = $urandom; beat_strb[i] = 4'($urandom);
                end
                write_txn(4'(n), ad, ln, sz, bu, bp, "rnd_wr");
            end else begin
                read_txn(4'(n), ad, ln, sz, bu, bp, $urandom_range(0, ln), -1, "rnd_rd");
            end
        end

        read_txn(4'd11, 32'h80, 7, 2, BURST_INCR, 0, 0, 2, "mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        read_txn(4'd12, 32'h80, 7, 2, BURST_INCR, 0, 0, -1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
